// File: rtl/dff_bist_driver_if.sv
// Signal bundle between the flip-flop BIST driver and its environment.
// master = the BIST driver, slave = the flop under test plus the controller issuing start.
interface dff_bist_driver_if;
  logic       start;
  logic       dut_q;
  logic       dut_d;
  logic       dut_rst;
  logic       dut_rst_n;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [7:0] fail_idx;

  modport master (
    input  start, dut_q,
    output dut_d, dut_rst, dut_rst_n, busy, done, pass, err_cnt, fail_idx
  );

  modport slave (
    output start, dut_q,
    input  dut_d, dut_rst, dut_rst_n, busy, done, pass, err_cnt, fail_idx
  );
endinterface

// File: rtl/dff_bist_driver.sv
// Self-test engine for D flops with sync active-high reset and async active-low clear:
// LFSR-driven stimulus, cycle-accurate golden q model, pass/fail and first-failure capture.
module dff_bist_driver #(
  parameter int         N_VEC        = 64,
  parameter logic [7:0] SEED         = 8'hA5,
  parameter bit         STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  dff_bist_driver_if.master bus
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LAST_IDX = 8'(N_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state, state_nx;
  logic [7:0] idx, idx_nx;
  logic [7:0] lfsr, lfsr_nx, lfsr_adv;
  logic       exp_q, exp_q_nx;
  logic       d_r, d_nx;
  logic       rst_r, rst_nx;
  logic       rst_n_r, rst_n_nx;
  logic       busy_r, busy_nx;
  logic       done_r, done_nx;
  logic       pass_r, pass_nx;
  logic [7:0] err_r, err_nx;
  logic [7:0] fidx_r, fidx_nx;
  logic       mismatch;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  assign lfsr_adv = lfsr_step(lfsr);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_nx = state;
    idx_nx   = idx;
    lfsr_nx  = lfsr;
    exp_q_nx = exp_q;
    d_nx     = d_r;
    rst_nx   = rst_r;
    rst_n_nx = rst_n_r;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    pass_nx  = pass_r;
    err_nx   = err_r;
    fidx_nx  = fidx_r;
    mismatch = 1'b0;

    case (state)
      S_IDLE: begin
        d_nx     = 1'b0;
        rst_nx   = 1'b0;
        rst_n_nx = 1'b1;
        if (bus.start) begin
          err_nx   = 8'h00;
          fidx_nx  = 8'hFF;
          pass_nx  = 1'b0;
          lfsr_nx  = SEED_EFF;
          idx_nx   = 8'h00;
          busy_nx  = 1'b1;
          rst_n_nx = 1'b0;
          state_nx = S_PRIME;
        end
      end

      S_PRIME: begin
        exp_q_nx = 1'b0;
        d_nx     = lfsr[0];
        rst_nx   = lfsr[2] & lfsr[1];
        rst_n_nx = ~(lfsr[5] & lfsr[4] & lfsr[3]);
        state_nx = S_DRIVE;
      end

      // The flop samples this vector at the edge leaving DRIVE; the model tracks the same edge.
      S_DRIVE: begin
        exp_q_nx = rst_n_r & ~rst_r & d_r;
        state_nx = S_CHECK;
      end

      S_CHECK: begin
        mismatch = (bus.dut_q != exp_q);
        if (mismatch) begin
          if (err_r != 8'hFF) err_nx = err_r + 8'd1;
          if (fidx_r == 8'hFF) fidx_nx = idx;
        end
        if ((mismatch && STOP_ON_FAIL) || (idx == LAST_IDX)) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (err_nx == 8'h00);
          d_nx     = 1'b0;
          rst_nx   = 1'b0;
          rst_n_nx = 1'b1;
          state_nx = S_DONE;
        end else begin
          lfsr_nx  = lfsr_adv;
          idx_nx   = idx + 8'd1;
          d_nx     = lfsr_adv[0];
          rst_nx   = lfsr_adv[2] & lfsr_adv[1];
          rst_n_nx = ~(lfsr_adv[5] & lfsr_adv[4] & lfsr_adv[3]);
          state_nx = S_DRIVE;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= 8'h00;
      lfsr    <= SEED_EFF;
      exp_q   <= 1'b0;
      d_r     <= 1'b0;
      rst_r   <= 1'b0;
      rst_n_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= 8'h00;
      fidx_r  <= 8'hFF;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      lfsr    <= lfsr_nx;
      exp_q   <= exp_q_nx;
      d_r     <= d_nx;
      rst_r   <= rst_nx;
      rst_n_r <= rst_n_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
      pass_r  <= pass_nx;
      err_r   <= err_nx;
      fidx_r  <= fidx_nx;
    end
  end

  assign bus.dut_d     = d_r;
  assign bus.dut_rst   = rst_r;
  assign bus.dut_rst_n = rst_n_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_cnt   = err_r;
  assign bus.fail_idx  = fidx_r;

endmodule
